// File: rtl/fakeram_port_driver_pkg.sv
// mem_port_pkg: shared widths and request record for the fakeram45_64x7 port driver
package mem_port_pkg;
  localparam int FAKERAM_ADDR_W = 6;
  localparam int FAKERAM_DATA_W = 7;
  localparam int RD_LAT = 1;
  typedef struct packed {
    logic                      we;
    logic [FAKERAM_ADDR_W-1:0] addr;
    logic [FAKERAM_DATA_W-1:0] wdata;
    logic [FAKERAM_DATA_W-1:0] wmask;
  } mem_req_t;
endpackage

// File: rtl/fakeram_port_driver_resp_fifo.sv
// resp_fifo: small in-order FIFO holding read data until the consumer takes it
module resp_fifo #(
  parameter int DATA_W = 7,
  parameter int RESP_DEPTH = 2,
  localparam int PW = $clog2(RESP_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [PW:0]       cnt
);
  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // empty slot reads as zero so resp_data is 0 after reset
  assign dout = empty ? '0 : mem[rp];
  assign full = cnt == (PW+1)'(RESP_DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/fakeram_port_driver.sv
// fakeram_port_driver: val/rdy request/response front end driving one fakeram macro port
module fakeram_port_driver
  import mem_port_pkg::*;
#(
  parameter int ADDR_W = FAKERAM_ADDR_W,
  parameter int DATA_W = FAKERAM_DATA_W,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic [DATA_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  logic rd_pend, acc, pop, empty, full;
  logic [CW-1:0] cnt, occ;
  // a read in flight already owns a FIFO slot, so it counts against the credit
  assign occ = cnt + CW'(rd_pend) - CW'(pop);
  assign req_rdy = !reset && occ < CW'(RESP_DEPTH);
  assign acc = req_val && req_rdy;
  assign pop = resp_val && resp_rdy;
  assign resp_val = !empty;
  assign mem_ce = acc;
  assign mem_we = acc && req_we;
  assign mem_addr = acc ? req_addr : '0;
  assign mem_wd = mem_we ? req_wdata : '0;
  assign mem_wmask = mem_we ? req_wmask : '0;
  always_ff @(posedge clk) begin
    rd_pend <= !reset && acc && !req_we;
  end
  resp_fifo #(.DATA_W(DATA_W), .RESP_DEPTH(RESP_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(rd_pend && !reset),
    .din(mem_rd),
    .pop(pop),
    .dout(resp_data),
    .full(full),
    .empty(empty),
    .cnt(cnt)
  );
  assert property (@(posedge clk) disable iff (reset) !(rd_pend && full));
endmodule
